// File: rtl/multi_cycle_control.sv
// Multi-cycle LEGv8 sequencer: Moore FSM that steps each instruction through
// fetch/decode/execute/memory/write-back, with bring-up cycle/retire counters.
module multi_cycle_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             Reset_L,
    input  logic [10:0]      Opcode,
    input  logic             IMemReady,
    input  logic             DMemReady,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IMemRead,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             Reg2Loc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             MemToReg,
    output logic             Halted,
    output logic [CNT_W-1:0] CycleCount,
    output logic [CNT_W-1:0] InstrRetired
);

    localparam int unsigned OPC_W = 11;

    localparam logic [OPC_W-1:0] OP_ADD  = 11'h458;
    localparam logic [OPC_W-1:0] OP_SUB  = 11'h658;
    localparam logic [OPC_W-1:0] OP_AND  = 11'h450;
    localparam logic [OPC_W-1:0] OP_ORR  = 11'h550;
    localparam logic [OPC_W-1:0] OP_LDUR = 11'h7C2;
    localparam logic [OPC_W-1:0] OP_STUR = 11'h7C0;
    localparam logic [7:0]       OP_CBZ  = 8'hB4;
    localparam logic [5:0]       OP_B    = 6'h05;

    localparam logic [1:0] SRCB_BUSB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_PASSB = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EX_R,
        S_EX_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_BR_CBZ,
        S_BR_B,
        S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0] instr_retired_q, instr_retired_d;

    logic is_rtype_c, is_ldur_c, is_stur_c, is_cbz_c, is_b_c;
    logic retire_c;

    logic       ir_write_c, pc_write_c, pc_write_cond_c, imem_read_c;
    logic       mem_read_c, mem_write_c, reg_write_c, reg2loc_c;
    logic       alu_src_a_c, mem_to_reg_c, halted_c;
    logic [1:0] alu_src_b_c, alu_op_c, pc_source_c;

    // Opcode classification; exact encodings take precedence over prefix matches
    always_comb begin
        is_rtype_c = (Opcode == OP_ADD) || (Opcode == OP_SUB) ||
                     (Opcode == OP_AND) || (Opcode == OP_ORR);
        is_ldur_c  = (Opcode == OP_LDUR);
        is_stur_c  = (Opcode == OP_STUR);
        is_cbz_c   = (Opcode[10:3] == OP_CBZ);
        is_b_c     = (Opcode[10:5] == OP_B);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   if (IMemReady) state_d = S_DECODE;
            S_DECODE: begin
                if (is_rtype_c)                  state_d = S_EX_R;
                else if (is_ldur_c || is_stur_c) state_d = S_EX_ADDR;
                else if (is_cbz_c)               state_d = S_BR_CBZ;
                else if (is_b_c)                 state_d = S_BR_B;
                else                             state_d = S_HALT;
            end
            S_EX_R:    state_d = S_WB_ALU;
            S_EX_ADDR: state_d = is_ldur_c ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  if (DMemReady) state_d = S_WB_MEM;
            S_MEM_WR:  if (DMemReady) state_d = S_FETCH;
            S_WB_ALU:  state_d = S_FETCH;
            S_WB_MEM:  state_d = S_FETCH;
            S_BR_CBZ:  state_d = S_FETCH;
            S_BR_B:    state_d = S_FETCH;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_HALT;
        endcase
    end

    // Counters: cycles freeze in HALT, retire on each instruction's final cycle
    always_comb begin
        retire_c = 1'b0;
        case (state_q)
            S_WB_ALU, S_WB_MEM, S_BR_CBZ, S_BR_B: retire_c = 1'b1;
            S_MEM_WR:                             retire_c = DMemReady;
            default:                              retire_c = 1'b0;
        endcase
        cycle_count_d   = (state_q == S_HALT) ? cycle_count_q
                                              : cycle_count_q + CNT_W'(1);
        instr_retired_d = retire_c ? instr_retired_q + CNT_W'(1) : instr_retired_q;
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q         <= S_FETCH;
            cycle_count_q   <= '0;
            instr_retired_q <= '0;
        end else begin
            state_q         <= state_d;
            cycle_count_q   <= cycle_count_d;
            instr_retired_q <= instr_retired_d;
        end
    end

    // Moore decode of datapath controls; only fetch write-enables look at ready
    always_comb begin
        ir_write_c      = 1'b0;
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        imem_read_c     = 1'b0;
        mem_read_c      = 1'b0;
        mem_write_c     = 1'b0;
        reg_write_c     = 1'b0;
        reg2loc_c       = 1'b0;
        alu_src_a_c     = 1'b0;
        alu_src_b_c     = SRCB_BUSB;
        alu_op_c        = ALU_ADD;
        pc_source_c     = PCSRC_ALU;
        mem_to_reg_c    = 1'b0;
        halted_c        = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_read_c = 1'b1;
                alu_src_b_c = SRCB_FOUR;
                ir_write_c  = IMemReady;
                pc_write_c  = IMemReady;
            end
            S_DECODE: begin
                alu_src_b_c = SRCB_IMMSH;
                reg2loc_c   = is_stur_c || is_cbz_c;
            end
            S_EX_R: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = ALU_FUNCT;
            end
            S_EX_ADDR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = SRCB_IMM;
            end
            S_MEM_RD: mem_read_c = 1'b1;
            S_MEM_WR: begin
                reg2loc_c   = 1'b1;
                mem_write_c = 1'b1;
            end
            S_WB_ALU: reg_write_c = 1'b1;
            S_WB_MEM: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
            end
            S_BR_CBZ: begin
                reg2loc_c       = 1'b1;
                alu_src_a_c     = 1'b1;
                alu_op_c        = ALU_PASSB;
                pc_write_cond_c = 1'b1;
                pc_source_c     = PCSRC_ALUOUT;
            end
            S_BR_B: begin
                pc_write_c  = 1'b1;
                pc_source_c = PCSRC_ALUOUT;
            end
            S_HALT:  halted_c = 1'b1;
            default: halted_c = 1'b0;
        endcase
    end

    // Reset low forces every control quiet, including the pending fetch request
    assign IRWrite      = Reset_L & ir_write_c;
    assign PCWrite      = Reset_L & pc_write_c;
    assign PCWriteCond  = Reset_L & pc_write_cond_c;
    assign IMemRead     = Reset_L & imem_read_c;
    assign MemRead      = Reset_L & mem_read_c;
    assign MemWrite     = Reset_L & mem_write_c;
    assign RegWrite     = Reset_L & reg_write_c;
    assign Reg2Loc      = Reset_L & reg2loc_c;
    assign ALUSrcA      = Reset_L & alu_src_a_c;
    assign ALUSrcB      = {2{Reset_L}} & alu_src_b_c;
    assign ALUOp        = {2{Reset_L}} & alu_op_c;
    assign PCSource     = {2{Reset_L}} & pc_source_c;
    assign MemToReg     = Reset_L & mem_to_reg_c;
    assign Halted       = Reset_L & halted_c;
    assign CycleCount   = cycle_count_q;
    assign InstrRetired = instr_retired_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: instruction-template reference model driven by
// random/directed opcodes and ready handshakes, checked every cycle.
module tb_multi_cycle_control;

    logic        CLK;
    logic        Reset_L;
    logic [10:0] Opcode;
    logic        IMemReady, DMemReady;
    logic        IRWrite, PCWrite, PCWriteCond, IMemRead, MemRead, MemWrite;
    logic        RegWrite, Reg2Loc, ALUSrcA, MemToReg, Halted;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic [31:0] CycleCount, InstrRetired;

    multi_cycle_control #(.CNT_W(32)) dut (
        .CLK(CLK), .Reset_L(Reset_L), .Opcode(Opcode),
        .IMemReady(IMemReady), .DMemReady(DMemReady),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .IMemRead(IMemRead), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .Reg2Loc(Reg2Loc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .MemToReg(MemToReg), .Halted(Halted),
        .CycleCount(CycleCount), .InstrRetired(InstrRetired)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    localparam int K_R = 0, K_LD = 1, K_ST = 2, K_CBZ = 3, K_B = 4, K_ILL = 5;

    int checks = 0;
    int failures = 0;

    // Reference model: position within the current instruction's cycle template
    int          m_step;
    bit          m_halted;
    logic [31:0] m_cyc, m_ret;
    logic [10:0] cur_op;
    logic [10:0] prog[$];

    bit rst_l_want;
    bit rnd_mode;
    bit dmr_hold_low;
    int dmr_low_left;

    int n_regwrite, n_memread, n_memwrite, n_memwrite_r2l, n_pcwc, n_wbmem;

    function automatic int classify(input logic [10:0] op);
        if (op == 11'h458 || op == 11'h658 || op == 11'h450 || op == 11'h550) return K_R;
        if (op == 11'h7C2) return K_LD;
        if (op == 11'h7C0) return K_ST;
        if (op[10:3] == 8'hB4) return K_CBZ;
        if (op[10:5] == 6'h05) return K_B;
        return K_ILL;
    endfunction

    function automatic int instr_len(input int kind);
        case (kind)
            K_R:     return 4;
            K_LD:    return 5;
            K_ST:    return 4;
            default: return 3;
        endcase
    endfunction

    function automatic logic [10:0] rand_legal();
        logic [10:0] r;
        int sel;
        r   = 11'($urandom);
        sel = $urandom_range(0, 7);
        case (sel)
            0: return 11'h458;
            1: return 11'h658;
            2: return 11'h450;
            3: return 11'h550;
            4: return 11'h7C2;
            5: return 11'h7C0;
            6: return {8'hB4, r[2:0]};
            default: return {6'h05, r[4:0]};
        endcase
    endfunction

    // Order: IRWrite PCWrite PCWriteCond IMemRead MemRead MemWrite RegWrite Reg2Loc
    //        ALUSrcA ALUSrcB ALUOp PCSource MemToReg Halted
    function automatic logic [16:0] m_expect(input bit rst_low, input bit halted,
                                             input int step, input int kind, input logic imr);
        logic irw, pcw, pcwc, imrd, mrd, mwr, rw, r2l, srca, m2r, hlt;
        logic [1:0] srcb, aluop, pcsrc;
        {irw, pcw, pcwc, imrd, mrd, mwr, rw, r2l, srca, m2r, hlt} = '0;
        srcb = 2'b00; aluop = 2'b00; pcsrc = 2'b00;
        if (rst_low) begin
        end else if (halted) begin
            hlt = 1'b1;
        end else if (step == 0) begin
            imrd = 1'b1; srcb = 2'b01; irw = imr; pcw = imr;
        end else if (step == 1) begin
            srcb = 2'b11; r2l = (kind == K_ST) || (kind == K_CBZ);
        end else if (step == 2) begin
            case (kind)
                K_R:        begin srca = 1'b1; aluop = 2'b10; end
                K_LD, K_ST: begin srca = 1'b1; srcb = 2'b10; end
                K_CBZ:      begin r2l = 1'b1; srca = 1'b1; aluop = 2'b01; pcwc = 1'b1; pcsrc = 2'b01; end
                K_B:        begin pcw = 1'b1; pcsrc = 2'b01; end
                default:    begin end
            endcase
        end else if (step == 3) begin
            case (kind)
                K_R:     rw = 1'b1;
                K_LD:    mrd = 1'b1;
                K_ST:    begin r2l = 1'b1; mwr = 1'b1; end
                default: begin end
            endcase
        end else if (step == 4 && kind == K_LD) begin
            rw = 1'b1; m2r = 1'b1;
        end
        return {irw, pcw, pcwc, imrd, mrd, mwr, rw, r2l, srca, srcb, aluop, pcsrc, m2r, hlt};
    endfunction

    function automatic logic [16:0] act_vec();
        return {IRWrite, PCWrite, PCWriteCond, IMemRead, MemRead, MemWrite, RegWrite,
                Reg2Loc, ALUSrcA, ALUSrcB, ALUOp, PCSource, MemToReg, Halted};
    endfunction

    task automatic m_reset();
        m_step = 0; m_halted = 1'b0; m_cyc = '0; m_ret = '0;
    endtask

    // Advance the model on a rising edge using the inputs present at that edge
    task automatic model_step();
        int kind;
        bit waiting;
        if (!Reset_L || m_halted) return;
        kind = classify(cur_op);
        m_cyc = m_cyc + 32'd1;
        if (m_step == 0) begin
            if (IMemReady) m_step = 1;
        end else if (m_step == 1 && kind == K_ILL) begin
            m_halted = 1'b1;
        end else begin
            waiting = (m_step == 3) && (kind == K_LD || kind == K_ST);
            if (waiting && !DMemReady) begin
            end else if (m_step == instr_len(kind) - 1) begin
                m_ret = m_ret + 32'd1;
                m_step = 0;
            end else begin
                m_step = m_step + 1;
            end
        end
    endtask

    task automatic drive();
        int kind;
        Reset_L = rst_l_want;
        if (!m_halted && m_step == 0) begin
            Opcode = 11'($urandom);
        end else if (!m_halted && m_step == 1) begin
            cur_op = (prog.size() > 0) ? prog.pop_front() : rand_legal();
            Opcode = cur_op;
        end else begin
            Opcode = cur_op;
        end
        kind = classify(cur_op);
        IMemReady = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        DMemReady = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (dmr_hold_low) begin
            DMemReady = 1'b0;
        end else if (dmr_low_left > 0 && !m_halted && m_step == 3 && kind == K_LD) begin
            DMemReady = 1'b0;
            dmr_low_left = dmr_low_left - 1;
        end
    endtask

    task automatic check_cycle();
        logic [16:0] exp_v, act_v;
        exp_v = m_expect(!Reset_L, m_halted, m_step, classify(cur_op), IMemReady);
        act_v = act_vec();
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL outputs t=%0t step=%0d op=%h act=%05h exp=%05h",
                     $time, m_step, cur_op, act_v, exp_v);
        end
        checks++;
        if (CycleCount !== m_cyc) begin
            failures++;
            $display("FAIL cycle_count t=%0t act=%0d exp=%0d", $time, CycleCount, m_cyc);
        end
        checks++;
        if (InstrRetired !== m_ret) begin
            failures++;
            $display("FAIL instr_retired t=%0t act=%0d exp=%0d", $time, InstrRetired, m_ret);
        end
        if (RegWrite) n_regwrite++;
        if (MemRead) n_memread++;
        if (MemWrite) n_memwrite++;
        if (MemWrite && Reg2Loc) n_memwrite_r2l++;
        if (PCWriteCond && PCSource == 2'b01) n_pcwc++;
        if (RegWrite && MemToReg) n_wbmem++;
    endtask

    task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic clear_tallies();
        n_regwrite = 0; n_memread = 0; n_memwrite = 0;
        n_memwrite_r2l = 0; n_pcwc = 0; n_wbmem = 0;
    endtask

    task automatic run_cycle_pre();
        @(negedge CLK);
        drive();
        #1;
        check_cycle();
    endtask

    task automatic run_cycle_post();
        @(posedge CLK);
        model_step();
    endtask

    task automatic run_cycle();
        run_cycle_pre();
        run_cycle_post();
    endtask

    task automatic async_reset_now();
        Reset_L = 1'b0;
        rst_l_want = 1'b0;
        m_reset();
        #1;
        check_cycle();
    endtask

    task automatic release_and_check();
        rst_l_want = 1'b1;
        run_cycle_pre();
        expect_eq("imemread_after_release", 32'(IMemRead), 32'd1);
        expect_eq("cycle_count_at_release", CycleCount, 32'd0);
        run_cycle_post();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        Reset_L = 1'b0; rst_l_want = 1'b0;
        Opcode = '0; IMemReady = 1'b0; DMemReady = 1'b0;
        cur_op = '0; rnd_mode = 1'b0; dmr_hold_low = 1'b0; dmr_low_left = 0;
        m_reset();
        clear_tallies();

        // Reset held three cycles with everything quiet
        repeat (2) run_cycle();
        run_cycle_pre();
        expect_eq("imemread_in_reset", 32'(IMemRead), 32'd0);
        expect_eq("outputs_in_reset", 32'(act_vec()), 32'd0);
        run_cycle_post();

        // ADD, ready tied high: four cycles, one register write
        prog.push_back(11'h458);
        release_and_check();
        repeat (3) run_cycle();
        #1;
        expect_eq("add_retired", InstrRetired, 32'd1);
        expect_eq("add_cycles", CycleCount, 32'd4);
        expect_eq("add_regwrite_cycles", n_regwrite, 32'd1);

        // LDUR with two data-memory wait cycles
        clear_tallies();
        prog.push_back(11'h7C2);
        dmr_low_left = 2;
        repeat (7) run_cycle();
        #1;
        expect_eq("ldur_cycles", CycleCount, 32'd11);
        expect_eq("ldur_retired", InstrRetired, 32'd2);
        expect_eq("ldur_memread_cycles", n_memread, 32'd3);
        expect_eq("ldur_wbmem_cycles", n_wbmem, 32'd1);

        // STUR then CBZ
        clear_tallies();
        prog.push_back(11'h7C0);
        prog.push_back(11'h5A0);
        repeat (7) run_cycle();
        #1;
        expect_eq("stur_cbz_retired", InstrRetired, 32'd4);
        expect_eq("stur_cbz_cycles", CycleCount, 32'd18);
        expect_eq("stur_memwrite_cycles", n_memwrite, 32'd1);
        expect_eq("stur_memwrite_reg2loc", n_memwrite_r2l, 32'd1);
        expect_eq("cbz_pcwritecond_cycles", n_pcwc, 32'd1);

        // Random legal programs with random handshakes and mid-cycle resets
        rnd_mode = 1'b1;
        for (int chunk = 0; chunk < 4; chunk++) begin
            repeat (150) run_cycle();
            #($urandom_range(1, 4));
            async_reset_now();
            repeat ($urandom_range(1, 2)) run_cycle();
            release_and_check();
        end
        rnd_mode = 1'b0;

        // STUR aborted by reset while stalled in its write
        @(negedge CLK);
        #2;
        async_reset_now();
        run_cycle();
        prog.push_back(11'h7C0);
        dmr_hold_low = 1'b1;
        release_and_check();
        guard = 0;
        while (!(m_step == 3 && classify(cur_op) == K_ST) && guard < 20) begin
            run_cycle();
            guard++;
        end
        expect_eq("reach_mem_wr_within_bound", 32'(guard < 20), 32'd1);
        repeat (2) run_cycle();
        #1;
        expect_eq("memwrite_before_abort", 32'(MemWrite), 32'd1);
        #2;
        async_reset_now();
        expect_eq("memwrite_after_abort", 32'(MemWrite), 32'd0);
        expect_eq("retired_after_abort", InstrRetired, 32'd0);
        run_cycle();
        dmr_hold_low = 1'b0;

        // Illegal opcode halts; counters freeze; reset recovers
        prog.push_back(11'h7FF);
        release_and_check();
        run_cycle();
        #1;
        expect_eq("halted_after_decode", 32'(Halted), 32'd1);
        clear_tallies();
        repeat (10) run_cycle();
        #1;
        expect_eq("halt_cycle_count_frozen", CycleCount, 32'd2);
        expect_eq("halt_no_regwrite", n_regwrite + n_memwrite + n_memread, 32'd0);
        #2;
        async_reset_now();
        expect_eq("halted_cleared_by_reset", 32'(Halted), 32'd0);
        run_cycle();
        release_and_check();
        repeat (5) run_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
